power1_detector: RTL and testbench

- Detects whether the 3-bit value on a[2:0] is an exact power of two, meaning exactly one bit is set (values 1, 2 or 4).
- The flag is registered: one clock, asynchronous active-high reset.
- Used as a small classification primitive inside larger datapaths and exercise benches.
- Bit a[3] is reserved and ignored, so an undriven or X a[3] never corrupts the result.

---
 rtl/power1_detector_pkg.sv | 8 +
 rtl/power1_detector_one_hot3.sv | 15 +
 rtl/power1_detector.sv | 34 +++
 tb/tb_power1_detector.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/power1_detector_pkg.sv
// Shared constants for the power-of-two detector.
// The operand is 4 bits wide; only the low 3 bits take part in the classification.
package power1_detector_pkg;

  localparam int SIG_BITS = 3;
  localparam int A_WIDTH  = 4;

endpackage

// File: rtl/power1_detector_one_hot3.sv
// Pure combinational exactly-one-bit detector on a 3-bit value.
// Can be reused by other classifiers that need the same test.
module one_hot3
  import power1_detector_pkg::*;
(
  input  logic [SIG_BITS-1:0] i_bits,
  output logic                o_one_hot
);

  // Zero and multi-bit values both fall through to 0.
  assign o_one_hot = (i_bits == 3'b001) |
                     (i_bits == 3'b010) |
                     (i_bits == 3'b100);

endmodule

// File: rtl/power1_detector.sv
// Registered power-of-two flag for a[2:0].
// a[3] is reserved and never reaches the logic, so X/Z on it cannot disturb y.
module power1_detector
  import power1_detector_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] a,
  output logic               y
);

  logic w_one_hot;
  logic w_unused_a3;
  logic r_y;

  one_hot3 u_one_hot3 (
    .i_bits    (a[SIG_BITS-1:0]),
    .o_one_hot (w_one_hot)
  );

  // Reserved bit is tied off here so it is visibly consumed but drives nothing.
  assign w_unused_a3 = a[A_WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y <= 1'b0;
    end else begin
      r_y <= w_one_hot;
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_power1_detector.sv
// Self-checking bench for power1_detector.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_power1_detector;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       y;

  logic [0:0] exp_q[$];
  logic       exp_y;
  int         total;
  int         bad;

  power1_detector dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .y   (y)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: popcount of the significant bits equals one.
  function automatic logic model(input logic [2:0] v);
    return ($countones(v) == 1);
  endfunction

  // Driver: apply an operand and record what y must show after the next edge.
  task automatic drive_a(input logic [3:0] v);
    a = v;
    exp_q.push_back(model(v[2:0]));
  endtask

  task automatic test_reset();
    a   = 4'b0001;
    rst = 1'b1;
    #2;
    total++;
    if (y !== 1'b0) begin
      bad++;
      $display("FAIL reset_initial y=%b expected=0", y);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (y !== 1'b0) begin
        bad++;
        $display("FAIL reset_held cycle=%0d y=%b expected=0", i, y);
      end
    end
    rst = 1'b0;
    #3;
    total++;
    if (y !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_pre_edge y=%b expected=0", y);
    end
    @(posedge clk);
    #1;
    total++;
    if (y !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_post_edge y=%b expected=1", y);
    end
  endtask

  task automatic test_sweep(input logic msb, input string tag);
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      drive_a({msb, v});
      @(posedge clk);
      #1;
      exp_y = exp_q.pop_front();
      total++;
      if (y !== exp_y) begin
        bad++;
        $display("FAIL sweep_%s a=%b y=%b expected=%b", tag, v, y, exp_y);
      end
    end
  endtask

  task automatic test_latency();
    drive_a(4'b0011);
    @(posedge clk);
    #1;
    exp_y = exp_q.pop_front();
    total++;
    if (y !== exp_y) begin
      bad++;
      $display("FAIL latency_setup y=%b expected=%b", y, exp_y);
    end
    drive_a(4'b0100);
    #3;
    total++;
    if (y !== 1'b0) begin
      bad++;
      $display("FAIL latency_before_edge y=%b expected=0", y);
    end
    @(posedge clk);
    #1;
    exp_y = exp_q.pop_front();
    total++;
    if (y !== exp_y) begin
      bad++;
      $display("FAIL latency_after_edge y=%b expected=%b", y, exp_y);
    end
  endtask

  task automatic test_midstream_reset();
    drive_a(4'b0010);
    @(posedge clk);
    #1;
    exp_y = exp_q.pop_front();
    total++;
    if (y !== exp_y) begin
      bad++;
      $display("FAIL midreset_setup y=%b expected=%b", y, exp_y);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (y !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async_clear y=%b expected=0", y);
    end
    rst = 1'b0;
    #1;
    total++;
    if (y !== 1'b0) begin
      bad++;
      $display("FAIL midreset_after_release y=%b expected=0", y);
    end
    @(posedge clk);
    #1;
    total++;
    if (y !== 1'b1) begin
      bad++;
      $display("FAIL midreset_recover y=%b expected=1", y);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive_a((i % 2 == 0) ? 4'b0001 : 4'b0111);
      @(posedge clk);
      #1;
      exp_y = exp_q.pop_front();
      total++;
      if (y !== exp_y) begin
        bad++;
        $display("FAIL back_to_back cycle=%0d y=%b expected=%b", i, y, exp_y);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] v;
    for (int i = 0; i < 24; i++) begin
      v = 4'($urandom_range(0, 15));
      drive_a(v);
      @(posedge clk);
      #1;
      exp_y = exp_q.pop_front();
      total++;
      if (y !== exp_y) begin
        bad++;
        $display("FAIL random a=%b y=%b expected=%b", v, y, exp_y);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    a     = 4'b0000;
    test_reset();
    test_sweep(1'b0, "msb0");
    test_sweep(1'b1, "msb1");
    test_sweep(1'bx, "msbx");
    test_latency();
    test_midstream_reset();
    test_back_to_back();
    test_random();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover size=%0d expected=0", exp_q.size());
    end
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
